// File: rtl/sample_uart_logger.sv
// sample_uart_logger
//   Buffers 8-bit ADC samples from the SPI leader in a synchronous FIFO and
//   drains them over a UART 8N1 transmitter (LSB first, idle high).
// Ports
//   clk          system clock, rising edge
//   RESET        synchronous, active-high reset
//   sample_valid one-cycle strobe qualifying sample_word
//   sample_word  8-bit ADC sample
//   tx           UART serial output, idle high
//   busy         high while a frame is in progress
//   fifo_count   number of buffered samples (0..2**FIFO_AW)
//   overflow     sticky flag: a sample was dropped because the FIFO was full
module sample_uart_logger #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               sample_valid,
  input  logic [7:0]         sample_word,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int DEPTH  = 2 ** FIFO_AW;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]  BAUD_ONE  = BAUD_W'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;

  state_t             state;
  logic [BAUD_W-1:0]  baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Pop decision uses the pre-edge count, so a sample written into an empty
  // FIFO is not visible to the transmitter until the following edge.
  always_comb begin
    full  = (fifo_count == CNT_FULL);
    empty = (fifo_count == '0);
    push  = sample_valid && !full;
    pop   = (state == IDLE) && !empty;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_word;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_ONE;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CNT_ONE;
      end
      // A full FIFO drops the sample even when a pop frees a slot this edge.
      if (sample_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          baud    <= '0;
          bit_idx <= '0;
          if (!empty) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              // shift[0] is the bit currently on the line; expose the next one.
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          baud  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_uart_logger.sv
// tb_sample_uart_logger
//   Drives sample_uart_logger (CLKS_PER_BIT=4, FIFO_AW=4) with directed and
//   random sample streams, compares every cycle against a queue-based frame
//   model, and decodes tx with an independent UART receiver.
module tb_sample_uart_logger;

  localparam int C     = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic          sample_valid = 1'b0;
  logic [7:0]    sample_word = '0;
  logic          tx;
  logic          busy;
  logic [AW:0]   fifo_count;
  logic          overflow;

  sample_uart_logger #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
    .clk          (clk),
    .RESET        (RESET),
    .sample_valid (sample_valid),
    .sample_word  (sample_word),
    .tx           (tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered samples, elapsed cycles of the current frame
  // (0 = idle, 1..10*C = inside the frame), byte on the wire, sticky overflow.
  logic [7:0] mq [$];
  int         m_e = 0;
  logic [7:0] m_cur = '0;
  bit         m_ovf = 1'b0;
  logic [7:0] sent [$];

  // Receiver output.
  logic [7:0] rxq [$];
  int         rx_ferr = 0;
  int         max_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] w, input logic r);
    bit do_pop;
    bit is_full;
    if (r) begin
      if (m_e != 0) void'(sent.pop_back());
      mq.delete();
      m_e   = 0;
      m_ovf = 1'b0;
    end else begin
      do_pop  = (m_e == 0) && (mq.size() > 0);
      is_full = (mq.size() == DEPTH);
      if (m_e != 0) begin
        m_e = (m_e == 10 * C) ? 0 : m_e + 1;
      end else if (do_pop) begin
        m_cur = mq.pop_front();
        m_e   = 1;
        sent.push_back(m_cur);
      end
      if (v) begin
        if (is_full) m_ovf = 1'b1;
        else mq.push_back(w);
      end
    end
  endtask

  function automatic logic exp_tx();
    int idx;
    if (m_e == 0) return 1'b1;
    idx = (m_e - 1) / C;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  task automatic tick(input logic v, input logic [7:0] w, input logic r);
    sample_valid = v;
    sample_word  = w;
    RESET        = r;
    @(posedge clk);
    model_step(v, w, r);
    @(negedge clk);
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    check("tx", {31'b0, tx}, {31'b0, exp_tx()});
    check("busy", {31'b0, busy}, {31'b0, m_e != 0});
    check("fifo_count", {27'b0, fifo_count}, mq.size());
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  // UART receiver sampling mid-bit on the falling edge; aborts on RESET.
  initial begin
    bit         active = 1'b0;
    int         cnt = 0;
    logic [7:0] b = '0;
    forever begin
      @(negedge clk);
      if (!active) begin
        if (tx === 1'b0 && RESET === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (RESET !== 1'b0) begin
          active = 1'b0;
        end else begin
          for (int i = 0; i < 8; i++)
            if (cnt == C * (i + 1) + C / 2) b[i] = tx;
          if (cnt == 9 * C + C / 2) begin
            if (tx === 1'b1) rxq.push_back(b);
            else rx_ferr++;
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int rx_before;
    logic [7:0] v;

    // 1: reset and quiet hold
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_count", {27'b0, fifo_count}, 32'd0);
    idle(20);

    // 2: single frame
    tick(1'b1, 8'hA5, 1'b0);
    idle(50);

    // 3: three back-to-back samples
    max_cnt = 0;
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, 8'h03, 1'b0);
    idle(130);
    check("s3_peak_count", max_cnt, 32'd2);

    // 4: overrun the FIFO
    max_cnt   = 0;
    rx_before = rxq.size();
    for (int i = 0; i < 18; i++) tick(1'b1, 8'(i), 1'b0);
    idle(17 * (10 * C + 1) + 20);
    check("s4_peak_count", max_cnt, 32'd16);
    check("s4_frames", rxq.size() - rx_before, 32'd17);
    check("s4_overflow_sticky", {31'b0, overflow}, 32'd1);

    // 5: reset in the middle of a frame with samples queued
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, 8'h03, 1'b0);
    idle(12);
    tick(1'b0, 8'h00, 1'b1);
    check("s5_tx_after_reset", {31'b0, tx}, 32'd1);
    check("s5_count_after_reset", {27'b0, fifo_count}, 32'd0);
    check("s5_ovf_after_reset", {31'b0, overflow}, 32'd0);
    tick(1'b1, 8'h3C, 1'b0);
    idle(50);

    // 6: random samples, pointers wrap
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom_range(0, 255));
      tick(1'b1, v, 1'b0);
      idle(49);
    end
    idle(10);
    check("s6_overflow", {31'b0, overflow}, 32'd0);

    // Everything decoded on the line must match what the model sent.
    check("rx_framing_errors", rx_ferr, 32'd0);
    check("rx_frame_count", rxq.size(), sent.size());
    for (int i = 0; i < sent.size() && i < rxq.size(); i++)
      check("rx_byte", {24'b0, rxq[i]}, {24'b0, sent[i]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
